// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB4 register-file completer.
package apb_pkg;

  // state  | meaning
  // IDLE   | no transfer in flight, waiting for a SETUP phase
  // ACCESS | transfer captured, counting wait states or presenting pready
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // Widest data path the lane helper supports; narrower words are
  // zero-extended on the way in and truncated on the way out.
  localparam int LANE_MAX_W = 256;
  localparam int LANE_MAX_B = LANE_MAX_W / 8;

  // Replace every byte of old_word whose strobe bit is set with the
  // matching byte of new_word.
  function automatic logic [LANE_MAX_W-1:0] lane_merge(
    input logic [LANE_MAX_W-1:0] old_word,
    input logic [LANE_MAX_W-1:0] new_word,
    input logic [LANE_MAX_B-1:0] strb
  );
    logic [LANE_MAX_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < LANE_MAX_B; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb_reg_array.sv
// Flop-based register array: one byte-enabled write port, one
// combinational read port, synchronous active-low clear of every word.
module apb_reg_array
  import apb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear has priority over the write port so a reset edge never commits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= DATA_W'(lane_merge(LANE_MAX_W'(mem[waddr]),
                                       LANE_MAX_W'(wdata),
                                       LANE_MAX_B'(wstrb)));
    end
  end

  // Callers only use rdata when the index is below DEPTH.
  assign rdata = mem[raddr];

endmodule

// File: rtl/apb4_regfile_slave.sv
// APB4 completer in front of a flop register array, with programmable
// wait states, byte-strobe writes, pslverr on out-of-range words and
// abort when psel drops mid-transfer.
//
// state  | meaning
// IDLE   | waiting for psel=1, penable=0 (SETUP)
// ACCESS | request captured; pready rises after WAIT_CYCLES, completes or aborts
module apb4_regfile_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic [ADDR_W-1:0]   paddr_i,
  input  logic                pwrite_i,
  input  logic [DATA_W-1:0]   pwdata_i,
  input  logic [DATA_W/8-1:0] pstrb_i,
  output logic [DATA_W-1:0]   prdata_o,
  output logic                pready_o,
  output logic                pslverr_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  apb_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;

  logic              setup_phase;
  logic              commit;
  logic              addr_q_ok;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_write;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_value;
  logic              rd_err;

  assign setup_phase = psel_i & ~penable_i;
  assign addr_q_ok   = ({1'b0, addr_q} < DEPTH_EXT);

  // Zero-wait transfers load the response on the SETUP edge itself, before
  // addr_q holds the request, so the response path looks at the live bus
  // while IDLE and at the captured request while in ACCESS.
  assign rd_addr  = (state == IDLE) ? paddr_i  : addr_q;
  assign rd_write = (state == IDLE) ? pwrite_i : write_q;
  assign rd_ok    = ({1'b0, rd_addr} < DEPTH_EXT);
  assign rd_value = (rd_ok && !rd_write) ? rd_word : '0;
  assign rd_err   = ~rd_ok;

  assign commit = (state == ACCESS) && psel_i && penable_i && pready_o
                  && write_q && addr_q_ok;

  apb_reg_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (commit),
    .waddr   (addr_q[IDX_W-1:0]),
    .wdata   (wdata_q),
    .wstrb   (strb_q),
    .raddr   (rd_addr[IDX_W-1:0]),
    .rdata   (rd_word)
  );

  // Transfer sequencer: capture on SETUP, count wait states, complete or abort.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // penable without a preceding SETUP is ignored here.
          if (setup_phase) begin
            addr_q   <= paddr_i;
            write_q  <= pwrite_i;
            wdata_q  <= pwdata_i;
            strb_q   <= pstrb_i;
            cnt      <= CNT_LOAD;
            state    <= ACCESS;
            pready_o <= (WAIT_CYCLES == 0);
            if (WAIT_CYCLES == 0) begin
              prdata_o  <= rd_value;
              pslverr_o <= rd_err;
            end
          end
        end
        ACCESS: begin
          if (!psel_i) begin
            state     <= IDLE;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            prdata_o  <= '0;
          end else if (penable_i) begin
            if (pready_o) begin
              state     <= IDLE;
              pready_o  <= 1'b0;
              pslverr_o <= 1'b0;
              prdata_o  <= '0;
            end else begin
              cnt <= cnt - 1'b1;
              if (cnt == CNT_LAST) begin
                pready_o  <= 1'b1;
                prdata_o  <= rd_value;
                pslverr_o <= rd_err;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_regfile_slave.sv
// Bench for apb4_regfile_slave: two instances (zero-wait full depth, and
// 3-wait-state 16-word), random and directed APB traffic, expected
// responses queued at issue time and checked by a completion monitor.
module tb_apb4_regfile_slave;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n   [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [9:0]  paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] model0 [1024];
  logic [31:0] model1 [16];

  apb4_regfile_slave #(
    .ADDR_W(10), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk(clk), .reset_n(rst_n[0]), .psel_i(psel[0]), .penable_i(penable[0]),
    .paddr_i(paddr[0]), .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]),
    .pstrb_i(pstrb[0]), .prdata_o(prdata[0]), .pready_o(pready[0]),
    .pslverr_o(pslverr[0])
  );

  apb4_regfile_slave #(
    .ADDR_W(10), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(3)
  ) u_dut1 (
    .clk(clk), .reset_n(rst_n[1]), .psel_i(psel[1]), .penable_i(penable[1]),
    .paddr_i(paddr[1]), .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]),
    .pstrb_i(pstrb[1]), .prdata_o(prdata[1]), .pready_o(pready[1]),
    .pslverr_o(pslverr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int depth_of(input int inst);
    return (inst == 0) ? 1024 : 16;
  endfunction

  function automatic int wait_of(input int inst);
    return (inst == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] model_read(input int inst, input logic [9:0] addr);
    if (int'(addr) >= depth_of(inst)) return 32'h0;
    return (inst == 0) ? model0[addr] : model1[addr[3:0]];
  endfunction

  task automatic model_write(input int inst, input logic [9:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] w;
    if (int'(addr) >= depth_of(inst)) return;
    w = model_read(inst, addr);
    for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
    if (inst == 0) model0[addr] = w;
    else           model1[addr[3:0]] = w;
  endtask

  task automatic model_clear(input int inst);
    if (inst == 0) for (int i = 0; i < 1024; i++) model0[i] = 32'h0;
    else           for (int i = 0; i < 16; i++)   model1[i] = 32'h0;
  endtask

  // Completion monitor: sampled on the falling edge, away from the active edge.
  task automatic monitor(input int inst);
    exp_t e;
    if (rst_n[inst] && psel[inst] && penable[inst] && pready[inst]) begin
      if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_completion inst%0d: got completion expected none", inst);
      end else begin
        e = (inst == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("prdata inst%0d", inst), prdata[inst], e.rdata);
        check($sformatf("pslverr inst%0d", inst), {31'h0, pslverr[inst]}, {31'h0, e.err});
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0);
    monitor(1);
  end

  task automatic bus_idle(input int inst);
    psel[inst]    = 1'b0;
    penable[inst] = 1'b0;
    pwrite[inst]  = 1'b0;
    paddr[inst]   = '0;
    pwdata[inst]  = '0;
    pstrb[inst]   = '0;
  endtask

  // One complete transfer; caller sits at posedge+1 with the bus idle.
  task automatic apb_xfer(input int inst, input logic wr, input logic [9:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    int   cyc;
    e.err   = (int'(addr) >= depth_of(inst));
    e.rdata = (!wr && !e.err) ? model_read(inst, addr) : 32'h0;
    if (wr) model_write(inst, addr, data, strb);
    if (inst == 0) q0.push_back(e); else q1.push_back(e);

    psel[inst] = 1'b1; penable[inst] = 1'b0; pwrite[inst] = wr;
    paddr[inst] = addr; pwdata[inst] = data; pstrb[inst] = strb;
    @(posedge clk); #1;
    penable[inst] = 1'b1;
    // Request fields must be ignored once captured.
    paddr[inst]  = 10'($urandom);
    pwdata[inst] = $urandom;
    pstrb[inst]  = 4'($urandom);
    pwrite[inst] = 1'($urandom);
    cyc = 0;
    while (!pready[inst] && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("wait_states inst%0d", inst), cyc, wait_of(inst));
    @(posedge clk); #1;
    bus_idle(inst);
    check($sformatf("ready_after_done inst%0d", inst), {31'h0, pready[inst]}, 32'h0);
  endtask

  // Start a write, spend n ACCESS cycles, then drop psel.
  task automatic apb_abort(input int inst, input logic [9:0] addr,
                           input logic [31:0] data, input int n);
    psel[inst] = 1'b1; penable[inst] = 1'b0; pwrite[inst] = 1'b1;
    paddr[inst] = addr; pwdata[inst] = data; pstrb[inst] = 4'hF;
    @(posedge clk); #1;
    penable[inst] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check($sformatf("abort_ready_low inst%0d", inst), {31'h0, pready[inst]}, 32'h0);
    end
    bus_idle(inst);
    @(posedge clk); #1;
    check($sformatf("abort_idle inst%0d", inst), {31'h0, pready[inst]}, 32'h0);
  endtask

  task automatic check_outputs_zero(input int inst, input string tag);
    check($sformatf("%s prdata inst%0d", tag, inst), prdata[inst], 32'h0);
    check($sformatf("%s pready inst%0d", tag, inst), {31'h0, pready[inst]}, 32'h0);
    check($sformatf("%s pslverr inst%0d", tag, inst), {31'h0, pslverr[inst]}, 32'h0);
  endtask

  initial begin
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        w;

    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      bus_idle(i);
      model_clear(i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero(0, "reset");
    check_outputs_zero(1, "reset");
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Zero-wait instance: directed cases.
    apb_xfer(0, 1'b1, 10'h005, 32'h0000_BEEF, 4'hF);
    apb_xfer(0, 1'b0, 10'h005, 32'h0, 4'h0);
    apb_xfer(0, 1'b1, 10'h020, 32'hAABB_CCDD, 4'hF);
    apb_xfer(0, 1'b1, 10'h020, 32'h1122_3344, 4'h5);
    apb_xfer(0, 1'b0, 10'h020, 32'h0, 4'h0);
    apb_xfer(0, 1'b1, 10'h3FF, 32'hCAFE_F00D, 4'hF);
    apb_xfer(0, 1'b0, 10'h3FF, 32'h0, 4'h0);
    apb_xfer(0, 1'b1, 10'h005, 32'hFFFF_FFFF, 4'h0);
    apb_xfer(0, 1'b0, 10'h005, 32'h0, 4'h0);

    // penable while idle must not start anything.
    penable[0] = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_penable pready inst0", {31'h0, pready[0]}, 32'h0);
    end
    psel[0] = 1'b1;
    @(posedge clk); #1;
    check("idle_psel_penable pready inst0", {31'h0, pready[0]}, 32'h0);
    bus_idle(0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 31));
      w = 1'($urandom);
      d = $urandom;
      s = 4'($urandom);
      apb_xfer(0, w, a, d, s);
    end

    // Waited, 16-word instance: first the ten addresses used by the reset case.
    for (int i = 0; i < 10; i++) apb_xfer(1, 1'b1, 10'(i), $urandom | 32'h1, 4'hF);
    apb_xfer(1, 1'b0, 10'h003, 32'h0, 4'h0);
    apb_xfer(1, 1'b1, 10'h011, 32'h0000_1234, 4'hF);
    apb_xfer(1, 1'b0, 10'h011, 32'h0, 4'h0);
    apb_xfer(1, 1'b0, 10'h001, 32'h0, 4'h0);
    apb_xfer(1, 1'b1, 10'h00F, 32'h5A5A_A5A5, 4'hF);
    apb_xfer(1, 1'b0, 10'h00F, 32'h0, 4'h0);
    apb_xfer(1, 1'b0, 10'h010, 32'h0, 4'h0);

    apb_abort(1, 10'h00C, 32'hDEAD_BEEF, 1);
    apb_xfer(1, 1'b0, 10'h00C, 32'h0, 4'h0);
    apb_abort(1, 10'h00C, 32'hDEAD_BEEF, 2);
    apb_xfer(1, 1'b0, 10'h00C, 32'h0, 4'h0);

    for (int i = 0; i < 30; i++) begin
      a = 10'($urandom_range(0, 19));
      w = 1'($urandom);
      d = $urandom;
      s = 4'($urandom);
      apb_xfer(1, w, a, d, s);
    end

    // Reset in the middle of a waited write.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 10'h002; pwdata[1] = 32'h7777_7777; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    bus_idle(1);
    @(negedge clk);
    check_outputs_zero(1, "midreset");
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    model_clear(1);
    for (int i = 0; i < 10; i++) apb_xfer(1, 1'b0, 10'(i), 32'h0, 4'h0);

    repeat (3) @(posedge clk);
    check("queue0_drained", q0.size(), 0);
    check("queue1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
